// File: rtl/sync_debounce_edge.sv
// Per-channel level debouncer with registered rise/fall pulses and a saturating
// transition counter. All logic runs on clk_A with a synchronous active-high reset.
module sync_debounce_edge #(
  parameter int unsigned     WIDTH         = 2,
  parameter int unsigned     STABLE_CYCLES = 4,
  parameter int unsigned     CNT_W         = 8,
  parameter logic [WIDTH-1:0] RST_VAL      = '0
) (
  input  logic             clk_A,
  input  logic             rst,
  input  logic [WIDTH-1:0] D_sync,
  input  logic             clear_cnt,
  output logic [WIDTH-1:0] D_deb,
  output logic [WIDTH-1:0] rise_p,
  output logic [WIDTH-1:0] fall_p,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int unsigned SC_W  = $clog2(STABLE_CYCLES) + 1;
  localparam int unsigned PC_W  = $clog2(WIDTH + 1);
  localparam int unsigned SUM_W = CNT_W + PC_W;

  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STABLE_CYCLES - 1);
  localparam logic [SUM_W-1:0] CNT_MAX = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

  logic [SC_W-1:0]  r_stab [WIDTH];
  logic [SC_W-1:0]  w_stab_nxt [WIDTH];
  logic [WIDTH-1:0] r_deb;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic [CNT_W-1:0] r_evt;

  logic [WIDTH-1:0] w_accept;
  logic [SUM_W-1:0] w_pop;
  logic [SUM_W-1:0] w_sum;
  logic [CNT_W-1:0] w_evt_nxt;

  // A matching sample clears the run, so glitches shorter than the window vanish.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_stab_nxt[i] = '0;
      if (D_sync[i] != r_deb[i]) begin
        if (r_stab[i] == SC_MAX) begin
          w_accept[i] = 1'b1;
        end else begin
          w_stab_nxt[i] = r_stab[i] + SC_W'(1);
        end
      end
    end
  end

  // Add in a widened domain so the saturation compare cannot overflow.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + SUM_W'(w_accept[i]);
    end
    w_sum = {{PC_W{1'b0}}, r_evt} + w_pop;
    if (w_sum > CNT_MAX) begin
      w_evt_nxt = {CNT_W{1'b1}};
    end else begin
      w_evt_nxt = w_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk_A) begin
    if (rst) begin
      r_deb  <= RST_VAL;
      r_rise <= '0;
      r_fall <= '0;
      r_evt  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_stab[i] <= '0;
      end
    end else begin
      r_deb  <= (r_deb & ~w_accept) | (D_sync & w_accept);
      r_rise <= w_accept & D_sync;
      r_fall <= w_accept & ~D_sync;
      for (int i = 0; i < WIDTH; i++) begin
        r_stab[i] <= w_stab_nxt[i];
      end
      if (clear_cnt) begin
        r_evt <= '0;
      end else begin
        r_evt <= w_evt_nxt;
      end
    end
  end

  assign D_deb   = r_deb;
  assign rise_p  = r_rise;
  assign fall_p  = r_fall;
  assign evt_cnt = r_evt;

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: one instance with an 8-bit event counter
// and a second with a 2-bit counter to exercise saturation and clear priority.
module tb_sync_debounce_edge;

  logic       clk_A = 1'b0;
  logic       rst_a, clr_a;
  logic [1:0] d_a, deb_a, rise_a, fall_a;
  logic [7:0] evt_a;

  logic       rst_b, clr_b;
  logic [1:0] d_b, deb_b, rise_b, fall_b;
  logic [1:0] evt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk_A = ~clk_A;

  sync_debounce_edge #(
    .WIDTH(2), .STABLE_CYCLES(4), .CNT_W(8), .RST_VAL(2'b00)
  ) u_dut_a (
    .clk_A(clk_A), .rst(rst_a), .D_sync(d_a), .clear_cnt(clr_a),
    .D_deb(deb_a), .rise_p(rise_a), .fall_p(fall_a), .evt_cnt(evt_a)
  );

  sync_debounce_edge #(
    .WIDTH(2), .STABLE_CYCLES(4), .CNT_W(2), .RST_VAL(2'b00)
  ) u_dut_b (
    .clk_A(clk_A), .rst(rst_b), .D_sync(d_b), .clear_cnt(clr_b),
    .D_deb(deb_b), .rise_p(rise_b), .fall_p(fall_b), .evt_cnt(evt_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_A);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [1:0] deb, input logic [1:0] rise,
                       input logic [1:0] fall, input logic [7:0] evt);
    check_eq({tag, ".deb"}, 32'(deb_a), 32'(deb));
    check_eq({tag, ".rise"}, 32'(rise_a), 32'(rise));
    check_eq({tag, ".fall"}, 32'(fall_a), 32'(fall));
    check_eq({tag, ".evt"}, 32'(evt_a), 32'(evt));
  endtask

  initial begin
    rst_a = 1'b1; clr_a = 1'b0; d_a = 2'b11;
    rst_b = 1'b1; clr_b = 1'b0; d_b = 2'b00;

    // Reset held two edges with inputs high.
    tick(); chk_a("rst1", 2'b00, 2'b00, 2'b00, 8'd0);
    tick(); chk_a("rst2", 2'b00, 2'b00, 2'b00, 8'd0);
    rst_a = 1'b0; d_a = 2'b00;
    tick(); chk_a("idle", 2'b00, 2'b00, 2'b00, 8'd0);

    // Single rise on channel 1.
    d_a = 2'b10;
    for (int k = 1; k <= 3; k++) begin
      tick(); chk_a($sformatf("rise_wait%0d", k), 2'b00, 2'b00, 2'b00, 8'd0);
    end
    tick(); chk_a("rise_acc", 2'b10, 2'b10, 2'b00, 8'd1);
    tick(); chk_a("rise_after", 2'b10, 2'b00, 2'b00, 8'd1);

    // Three-edge glitch on channel 0 is rejected.
    d_a = 2'b11;
    for (int k = 1; k <= 3; k++) begin
      tick(); chk_a($sformatf("glitch%0d", k), 2'b10, 2'b00, 2'b00, 8'd1);
    end
    d_a = 2'b10;
    tick(); chk_a("glitch_end", 2'b10, 2'b00, 2'b00, 8'd1);
    // Same pulse held four edges is accepted.
    d_a = 2'b11;
    repeat (3) tick();
    check_eq("four_wait.deb", 32'(deb_a), 32'h2);
    tick(); chk_a("four_acc", 2'b11, 2'b01, 2'b00, 8'd2);
    tick(); chk_a("four_after", 2'b11, 2'b00, 2'b00, 8'd2);

    // Simultaneous channels: fall both, rise both, fall both.
    d_a = 2'b00;
    repeat (3) tick();
    tick(); chk_a("both_fall1", 2'b00, 2'b00, 2'b11, 8'd4);
    d_a = 2'b11;
    repeat (3) tick();
    check_eq("both_rise_wait.deb", 32'(deb_a), 32'h0);
    tick(); chk_a("both_rise", 2'b11, 2'b11, 2'b00, 8'd6);
    d_a = 2'b00;
    repeat (3) tick();
    tick(); chk_a("both_fall2", 2'b00, 2'b00, 2'b11, 8'd8);
    tick(); chk_a("both_after", 2'b00, 2'b00, 2'b00, 8'd8);

    // Reset mid-count discards the partial run.
    d_a = 2'b01;
    repeat (2) tick();
    rst_a = 1'b1;
    tick(); chk_a("mid_rst", 2'b00, 2'b00, 2'b00, 8'd0);
    rst_a = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(); chk_a($sformatf("post_rst%0d", k), 2'b00, 2'b00, 2'b00, 8'd0);
    end
    tick(); chk_a("post_rst_acc", 2'b01, 2'b01, 2'b00, 8'd1);

    // Clear on an edge with an accepted transition: event not counted.
    d_a = 2'b00;
    repeat (3) tick();
    clr_a = 1'b1;
    tick(); chk_a("clr_evt", 2'b00, 2'b00, 2'b01, 8'd0);
    clr_a = 1'b0;
    tick(); chk_a("clr_after", 2'b00, 2'b00, 2'b00, 8'd0);

    // 2-bit counter: five toggles of channel 0 saturate at 3.
    tick();
    rst_b = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d_b = (k % 2 == 0) ? 2'b01 : 2'b00;
      repeat (4) tick();
      check_eq($sformatf("sat%0d.deb", k), 32'(deb_b), 32'(d_b));
      check_eq($sformatf("sat%0d.evt", k), 32'(evt_b), (k >= 2) ? 32'd3 : 32'(k + 1));
    end
    tick(); check_eq("sat_hold.evt", 32'(evt_b), 32'd3);
    d_b = 2'b00;
    repeat (3) tick();
    clr_b = 1'b1;
    tick();
    check_eq("b_clr.evt", 32'(evt_b), 32'd0);
    check_eq("b_clr.fall", 32'(fall_b), 32'h1);
    clr_b = 1'b0;
    d_b = 2'b10;
    repeat (4) tick();
    check_eq("b_post_clr.evt", 32'(evt_b), 32'd1);
    check_eq("b_post_clr.rise", 32'(rise_b), 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_debounce_edge.md
Name: sync_debounce_edge

Overview:
- Consumes the 2-bit synchronized data bus produced by the reset/data synchronizer stage in the clk_A domain.
- Filters each bit so that a new level is accepted only after it has been stable for STABLE_CYCLES consecutive clock edges.
- Emits one-cycle rise/fall pulses per bit and keeps a saturating count of accepted transitions for downstream control logic.

Parameters:
WIDTH, 2, number of independent channels (matches the synchronizer output width)
STABLE_CYCLES, 4, consecutive differing samples required before accepting a new level; must be >= 1
CNT_W, 8, width of the transition event counter
RST_VAL, 0, reset value of D_deb (WIDTH bits, same value for all channels' vector)

Ports:
clk_A  input  1  single clock; all logic on its rising edge
rst  input  1  synchronous, active-high reset
D_sync  input  WIDTH  synchronized input levels from the upstream synchronizer
clear_cnt  input  1  synchronous clear of evt_cnt
D_deb  output  WIDTH  debounced levels
rise_p  output  WIDTH  one-cycle pulse per channel on an accepted 0->1 transition
fall_p  output  WIDTH  one-cycle pulse per channel on an accepted 1->0 transition
evt_cnt  output  CNT_W  saturating count of accepted transitions, all channels

Behaviour:
- Reset: the interface is one clock, with a synchronous active-high reset. rst is sampled on the clk_A rising edge only and has priority over everything else.
- Reset values: D_deb=RST_VAL, rise_p=0, fall_p=0, evt_cnt=0, all per-channel stability counters=0.
- Per-channel counter: width is clog2(STABLE_CYCLES)+1.
- At each edge, if D_sync[i]==D_deb[i], counter[i] is set to 0. A glitch shorter than STABLE_CYCLES therefore leaves no trace.
- At each edge, if D_sync[i]!=D_deb[i] and counter[i] < STABLE_CYCLES-1, counter[i] increments.
- At each edge, if D_sync[i]!=D_deb[i] and counter[i]==STABLE_CYCLES-1, the transition is accepted:
  - D_deb[i] <= D_sync[i] and counter[i] <= 0.
  - rise_p[i] or fall_p[i] is set for exactly that one cycle.
- Latency: D_deb[i] changes on the STABLE_CYCLES-th consecutive edge that samples the new level. With STABLE_CYCLES=1, it changes on the first such edge.
- rise_p/fall_p are registered. Both are 0 in every cycle without an accepted transition. rise_p[i] and fall_p[i] are never both 1.
- Channels are fully independent. Simultaneous acceptances on several channels in the same cycle are legal.
- evt_cnt, per edge, in priority order:
  1. rst -> 0.
  2. Else clear_cnt -> 0. Clear wins over events on the same edge; those events are not counted.
  3. Else evt_cnt <= min(evt_cnt + popcount(accepted transitions this edge), 2^CNT_W-1).
- Saturation: evt_cnt holds at all-ones and never wraps. Saturation is computed with sufficient width to avoid overflow on the add.
- Reset mid-count: partial counts are discarded and D_deb returns to RST_VAL. A level that differs from RST_VAL after reset release needs a full STABLE_CYCLES new edges.
- D_sync is assumed already synchronous to clk_A. No additional synchronizer flops are included.

Test Plan:
Common setup: WIDTH=2, STABLE_CYCLES=4, CNT_W=8, RST_VAL=0, clk_A period 20 ns; "edge" = rising edge of clk_A.

1. Reset: rst=1 for 2 edges with D_sync=2'b11 -> D_deb=00, rise_p=fall_p=00, evt_cnt=0 throughout.
2. Single rise: after reset, D_sync 00->10 and held.
   - D_deb stays 00 for 3 edges, becomes 10 on the 4th.
   - rise_p=10 for exactly one cycle; evt_cnt=1.
3. Glitch rejection: D_sync[0]=1 for 3 edges, then 0 -> D_deb[0] stays 0, no pulse, evt_cnt unchanged. Repeat with 4 edges -> accepted.
4. Simultaneous channels:
   - From D_deb=00, D_sync=11 held 4 edges -> D_deb=11, rise_p=11 in one cycle, evt_cnt +2.
   - Then D_sync=00 held 4 edges -> fall_p=11, evt_cnt +2.
5. Reset mid-operation: D_sync=01 for 2 edges, rst=1 for 1 edge, rst=0 with D_sync=01 held.
   - D_deb[0] rises on the 4th edge after rst deasserts, not earlier.
   - evt_cnt=1.
6. Counter rules: CNT_W=2, toggle channel 0 five times -> evt_cnt reaches 3 and stays 3. Assert clear_cnt on an edge with an accepted transition -> evt_cnt=0.
